// File: rtl/octave_pkg.sv
// Shared types and constants for the octave button controller.
// Select encoding matches the octave datapath unit's opcode input.
package octave_pkg;

    localparam int OCT_W = 3;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_UP   = 2'd1;
    localparam logic [1:0] SEL_DOWN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_COMMIT   = 3'd4,
        ST_RELEASE  = 3'd5
    } state_e;

    function automatic logic [OCT_W-1:0] clamp_oct(
        input logic [OCT_W-1:0] v,
        input logic [OCT_W-1:0] lo,
        input logic [OCT_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/octave_ctrl_btn_sync.sv
// Two-flop synchroniser for one raw asynchronous button input.
// Output is metastability-filtered only; debouncing happens in the controller.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/octave_ctrl.sv
// Button-driven octave sequencer: debounces up/down presses, drives the
// external octave unit for one step per press and commits its result.
module octave_ctrl
    import octave_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int OCT_LAT    = 1,
    parameter int MIN_OCT    = 0,
    parameter int MAX_OCT    = 7,
    parameter int RESET_OCT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic [OCT_W-1:0] oct_out,
    output logic [1:0]       oct_select,
    output logic [OCT_W-1:0] oct_current,
    output logic [OCT_W-1:0] octave,
    output logic             busy,
    output logic             changed
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(OCT_LAT + 1);
    localparam int LAT_LAST_I = (OCT_LAT > 1) ? OCT_LAT - 2 : 0;

    localparam logic [CW-1:0]    CNT_MAX  = CW'(DEB_CYCLES);
    localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0]    LAT_LAST = LW'(LAT_LAST_I);
    localparam logic [OCT_W-1:0] OCT_MIN  = OCT_W'(MIN_OCT);
    localparam logic [OCT_W-1:0] OCT_MAX  = OCT_W'(MAX_OCT);
    localparam logic [OCT_W-1:0] OCT_RST  = OCT_W'(RESET_OCT);

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic up_s;
    logic dn_s;

    btn_sync u_sync_up (
        .clk     (clk),
        .rst     (rst_sync_q),
        .async_i (btn_up),
        .sync_o  (up_s)
    );

    btn_sync u_sync_dn (
        .clk     (clk),
        .rst     (rst_sync_q),
        .async_i (btn_down),
        .sync_o  (dn_s)
    );

    state_e           state_q;
    logic [1:0]       dir_q;
    logic [CW-1:0]    cnt_q;
    logic [LW-1:0]    lat_q;
    logic [1:0]       oct_select_q;
    logic [OCT_W-1:0] oct_current_q;
    logic [OCT_W-1:0] octave_q;
    logic             changed_q;

    logic             press_ok;
    logic             at_limit;
    logic [CW-1:0]    cnt_inc;
    logic [OCT_W-1:0] oct_clamped;

    always_comb begin
        press_ok = (dir_q == SEL_UP) ? (up_s & ~dn_s)
                                     : (dn_s & ~up_s);
        at_limit = ((dir_q == SEL_UP) && (octave_q == OCT_MAX))
                || ((dir_q == SEL_DOWN) && (octave_q == OCT_MIN));
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        oct_clamped = clamp_oct(oct_out, OCT_MIN, OCT_MAX);
    end

    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            state_q       <= ST_IDLE;
            dir_q         <= SEL_HOLD;
            cnt_q         <= '0;
            lat_q         <= '0;
            oct_select_q  <= SEL_HOLD;
            oct_current_q <= OCT_RST;
            octave_q      <= OCT_RST;
            changed_q     <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (up_s ^ dn_s) begin
                        dir_q   <= up_s ? SEL_UP : SEL_DOWN;
                        state_q <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!press_ok) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q <= '0;
                        if (at_limit) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            oct_select_q  <= dir_q;
                            oct_current_q <= octave_q;
                            state_q       <= ST_ISSUE;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_ISSUE: begin
                    lat_q <= '0;
                    if (OCT_LAT <= 1) begin
                        oct_select_q <= SEL_HOLD;
                        state_q      <= ST_COMMIT;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        oct_select_q <= SEL_HOLD;
                        state_q      <= ST_COMMIT;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    octave_q      <= oct_clamped;
                    oct_current_q <= oct_clamped;
                    changed_q     <= (oct_clamped != octave_q);
                    cnt_q         <= '0;
                    state_q       <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (up_s | dn_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    oct_select_q <= SEL_HOLD;
                    cnt_q        <= '0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign oct_select  = oct_select_q;
    assign oct_current = oct_current_q;
    assign octave      = octave_q;
    assign changed     = changed_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_octave_ctrl.sv
// Scoreboard bench for octave_ctrl with a behavioural one-cycle octave unit.
// Expected commits are queued at press time and popped on each changed pulse.
module tb_octave_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] oct_out;
    logic [1:0] oct_select;
    logic [2:0] oct_current;
    logic [2:0] octave;
    logic       busy;
    logic       changed;

    int checks = 0;
    int errors = 0;
    int sel_cnt = 0;
    int exp_oct = 4;
    logic [1:0] exp_sel = 2'd0;
    int sb_q[$];

    always #5 clk = ~clk;

    octave_ctrl #(
        .DEB_CYCLES (4),
        .OCT_LAT    (1),
        .MIN_OCT    (0),
        .MAX_OCT    (7),
        .RESET_OCT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .oct_out     (oct_out),
        .oct_select  (oct_select),
        .oct_current (oct_current),
        .octave      (octave),
        .busy        (busy),
        .changed     (changed)
    );

    // Octave unit: registered add/subtract, wraps like plain 3-bit math.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            oct_out <= 3'd4;
        else if (oct_select == 2'd1)
            oct_out <= oct_current + 3'd1;
        else if (oct_select == 2'd2)
            oct_out <= oct_current - 3'd1;
        else
            oct_out <= oct_current;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle of observation on the falling edge.
    task automatic tick();
        int e;
        @(negedge clk);
        if (changed === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_changed", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("commit_octave", int'(octave), e);
            end
        end
        if (oct_select !== 2'd0) begin
            sel_cnt++;
            chk("sel_dir", int'(oct_select), int'(exp_sel));
        end
    endtask

    task automatic press(input bit up, input bit dn, input int hi, input int lo);
        btn_up = up;
        btn_down = dn;
        repeat (hi) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic step(input bit up);
        int s0;
        bit can;
        s0 = sel_cnt;
        can = up ? (exp_oct < 7) : (exp_oct > 0);
        exp_sel = up ? 2'd1 : 2'd2;
        if (can) begin
            exp_oct = up ? exp_oct + 1 : exp_oct - 1;
            sb_q.push_back(exp_oct);
        end
        press(up, !up, 30, 30);
        chk(up ? "up_sel_cnt" : "dn_sel_cnt", sel_cnt - s0, can ? 1 : 0);
        chk("octave", int'(octave), exp_oct);
        chk("sb_drained", sb_q.size(), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        sb_q.delete();
        exp_oct = 4;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int s0;
        bit seen;

        // 1: reset and idle
        do_reset();
        chk("rst_octave", int'(octave), 4);
        chk("rst_current", int'(oct_current), 4);
        chk("rst_select", int'(oct_select), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (20) tick();
        chk("idle_octave", int'(octave), 4);
        chk("idle_busy", int'(busy), 0);
        chk("idle_sel_cnt", sel_cnt, 0);

        // 2: long hold gives a single step
        step(1'b1);

        // 3: climb to the top, last press blocked
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1);
        chk("top_octave", int'(octave), 7);

        // 4: glitch and both-buttons are ignored
        s0 = sel_cnt;
        press(1'b1, 1'b0, 2, 30);
        press(1'b1, 1'b1, 30, 30);
        chk("glitch_sel_cnt", sel_cnt - s0, 0);
        chk("glitch_octave", int'(octave), 7);

        // 5: descend to the bottom without wrap
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("bottom_octave", int'(octave), 0);

        // 6: reset while the request is in flight
        exp_sel = 2'd1;
        sb_q.push_back(1);
        btn_up = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (oct_select !== 2'd0) seen = 1'b1;
        end
        chk("issue_seen", int'(seen), 1);
        rst = 1'b1;
        #1;
        chk("abort_select", int'(oct_select), 0);
        chk("abort_octave", int'(octave), 4);
        sb_q.delete();
        exp_oct = 4;
        btn_up = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("abort_busy", int'(busy), 0);
        step(1'b1);
        chk("after_abort", int'(octave), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
